// File: rtl/spiflash_read_master.sv
// SPI-flash read initiator: mode 0, single-bit I/O.
// Sends READ_CMD plus a word-aligned 24-bit address, then shifts in one 32-bit word.
// The word is returned on a request/ack port with little-endian byte order.
module spiflash_read_master #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CSB_IDLE = 4,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        req,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oeb,
  input  logic        flash_io1_di
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDLE_W = $clog2(CSB_IDLE + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(CSB_IDLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [6:0]          bit_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [31:0]         tx_sr;
  logic [31:0]         rx_sr;
  logic                div_last;
  logic                idle_ok;
  logic [6:0]          bit_nxt;

  assign div_last = (div_cnt == DIV_LAST);
  assign idle_ok  = (idle_cnt == IDLE_MAX);
  assign bit_nxt  = bit_cnt + 7'd1;

  // Transfer sequencer: divider, bit counter, shift registers and all pin outputs.
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= IDLE_MAX;
      tx_sr         <= '0;
      rx_sr         <= '0;
      busy          <= 1'b0;
      ack           <= 1'b0;
      rdata         <= '0;
      flash_csb     <= 1'b1;
      flash_clk     <= 1'b0;
      flash_io0_do  <= 1'b0;
      flash_io0_oeb <= 1'b1;
    end else begin
      ack <= 1'b0;
      // Count cycles spent with csb high, saturating once the gap is long enough.
      if (flash_csb && !idle_ok) idle_cnt <= idle_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (req && idle_ok) begin
            state         <= S_SETUP;
            busy          <= 1'b1;
            flash_csb     <= 1'b0;
            flash_clk     <= 1'b0;
            flash_io0_oeb <= 1'b0;
            flash_io0_do  <= READ_CMD[7];
            tx_sr         <= {READ_CMD, addr & 24'hFFFFFC};
            div_cnt       <= '0;
            bit_cnt       <= '0;
          end
        end

        S_SETUP: begin
          if (div_last) begin
            state   <= S_SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!flash_clk) begin
              // Rising edge: the data phase samples MISO here.
              flash_clk <= 1'b1;
              if (bit_cnt[5]) rx_sr <= {rx_sr[30:0], flash_io1_di};
            end else begin
              // Falling edge: advance to the next bit and update MOSI while clk is low.
              flash_clk <= 1'b0;
              if (bit_cnt == 7'd63) begin
                state <= S_HOLD;
              end else begin
                bit_cnt <= bit_nxt;
                tx_sr   <= {tx_sr[30:0], 1'b0};
                if (bit_nxt[5]) begin
                  flash_io0_oeb <= 1'b1;
                  flash_io0_do  <= 1'b0;
                end else begin
                  flash_io0_do  <= tx_sr[30];
                end
              end
            end
          end
        end

        S_HOLD: begin
          if (div_last) begin
            state     <= S_DONE;
            div_cnt   <= '0;
            flash_csb <= 1'b1;
            idle_cnt  <= IDLE_W'(1);
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          ack   <= 1'b1;
          rdata <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_read_master.sv
// Directed bench for spiflash_read_master with a small behavioural SPI flash per instance.
module tb_spiflash_read_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_a, req_b;
  logic [23:0] addr_a, addr_b;
  logic        busy_a, ack_a, csb_a, fclk_a, do_a, oeb_a, miso_a;
  logic        busy_b, ack_b, csb_b, fclk_b, do_b, oeb_b, miso_b;
  logic [31:0] rdata_a, rdata_b;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:7];

  always #5 clk = ~clk;

  spiflash_read_master #(.CLK_DIV(2), .CSB_IDLE(4), .READ_CMD(8'h03)) dut_a (
    .core_clk(clk), .core_rstn(rstn), .req(req_a), .addr(addr_a),
    .busy(busy_a), .ack(ack_a), .rdata(rdata_a),
    .flash_csb(csb_a), .flash_clk(fclk_a), .flash_io0_do(do_a),
    .flash_io0_oeb(oeb_a), .flash_io1_di(miso_a)
  );

  spiflash_read_master #(.CLK_DIV(1), .CSB_IDLE(4), .READ_CMD(8'h03)) dut_b (
    .core_clk(clk), .core_rstn(rstn), .req(req_b), .addr(addr_b),
    .busy(busy_b), .ack(ack_b), .rdata(rdata_b),
    .flash_csb(csb_b), .flash_clk(fclk_b), .flash_io0_do(do_b),
    .flash_io0_oeb(oeb_b), .flash_io1_di(miso_b)
  );

  // Flash data bit n (MSB first per byte) of the sequential read starting at a.
  function automatic logic flash_bit(input logic [23:0] a, input int n);
    logic [23:0] ba;
    logic [7:0]  b;
    ba = a + 24'(n / 8);
    b  = mem[ba[2:0]];
    return b[3'(7 - (n % 8))];
  endfunction

  // Flash model A: captures MOSI on rising flash_clk, drives MISO after falling flash_clk.
  int          bits_a = 0;
  logic        pf_a = 1'b0;
  logic [31:0] mosi_a = '0;
  int          oe_err_a = 0;
  always @(negedge clk) begin
    if (csb_a) begin
      bits_a <= 0;
      pf_a   <= 1'b0;
    end else begin
      if (fclk_a && !pf_a) begin
        if (bits_a < 32) begin
          mosi_a <= {mosi_a[30:0], do_a};
          if (oeb_a) oe_err_a <= oe_err_a + 1;
        end else if (!oeb_a || do_a) begin
          oe_err_a <= oe_err_a + 1;
        end
        bits_a <= bits_a + 1;
      end else if (!fclk_a && pf_a && bits_a >= 32 && bits_a < 64) begin
        miso_a <= flash_bit(mosi_a[23:0], bits_a - 32);
      end
      pf_a <= fclk_a;
    end
  end

  // Flash model B: same behaviour for the CLK_DIV=1 instance.
  int          bits_b = 0;
  logic        pf_b = 1'b0;
  logic [31:0] mosi_b = '0;
  always @(negedge clk) begin
    if (csb_b) begin
      bits_b <= 0;
      pf_b   <= 1'b0;
    end else begin
      if (fclk_b && !pf_b) begin
        if (bits_b < 32) mosi_b <= {mosi_b[30:0], do_b};
        bits_b <= bits_b + 1;
      end else if (!fclk_b && pf_b && bits_b >= 32 && bits_b < 64) begin
        miso_b <= flash_bit(mosi_b[23:0], bits_b - 32);
      end
      pf_b <= fclk_b;
    end
  end

  // One read on instance A; lat = cycles from busy rise to ack (-1 on timeout), per = flash_clk period.
  task automatic read_a(input logic [23:0] a, input logic chg_addr, output int lat, output int per);
    int n, r1, r2;
    logic pf;
    addr_a = a;
    req_a  = 1'b1;
    lat = -1;
    per = -1;
    n = 0;
    while (!busy_a && n < 50) begin @(negedge clk); n++; end
    req_a = 1'b0;
    if (!busy_a) return;
    if (chg_addr) addr_a = 24'hABCDEF;
    n = 0; r1 = -1; r2 = -1; pf = fclk_a;
    while (!ack_a && n < 2000) begin
      @(negedge clk);
      n++;
      if (fclk_a && !pf) begin
        if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
      end
      pf = fclk_a;
    end
    if (ack_a) lat = n;
    if (r2 >= 0) per = r2 - r1;
  endtask

  // Same as read_a for instance B.
  task automatic read_b(input logic [23:0] a, output int lat, output int per);
    int n, r1, r2;
    logic pf;
    addr_b = a;
    req_b  = 1'b1;
    lat = -1;
    per = -1;
    n = 0;
    while (!busy_b && n < 50) begin @(negedge clk); n++; end
    req_b = 1'b0;
    if (!busy_b) return;
    n = 0; r1 = -1; r2 = -1; pf = fclk_b;
    while (!ack_b && n < 2000) begin
      @(negedge clk);
      n++;
      if (fclk_b && !pf) begin
        if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
      end
      pf = fclk_b;
    end
    if (ack_b) lat = n;
    if (r2 >= 0) per = r2 - r1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (csb_a !== 1'b1)    begin fails++; $display("FAIL reset_csb: got %b expected 1", csb_a); end
    tests++; if (fclk_a !== 1'b0)   begin fails++; $display("FAIL reset_clk: got %b expected 0", fclk_a); end
    tests++; if (oeb_a !== 1'b1)    begin fails++; $display("FAIL reset_oeb: got %b expected 1", oeb_a); end
    tests++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    tests++; if (ack_a !== 1'b0)    begin fails++; $display("FAIL reset_ack: got %b expected 0", ack_a); end
    tests++; if (rdata_a !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 00000000", rdata_a); end
    tests++; if (do_a !== 1'b0)     begin fails++; $display("FAIL reset_do: got %b expected 0", do_a); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_addr0();
    int lat, per;
    oe_err_a = 0;
    read_a(24'h000000, 1'b0, lat, per);
    tests++; if (lat !== 261)            begin fails++; $display("FAIL read0_latency: got %0d expected 261", lat); end
    tests++; if (rdata_a !== 32'h0B00006F) begin fails++; $display("FAIL read0_rdata: got %h expected 0b00006f", rdata_a); end
    tests++; if (mosi_a[31:24] !== 8'h03) begin fails++; $display("FAIL read0_cmd: got %h expected 03", mosi_a[31:24]); end
    tests++; if (mosi_a[23:0] !== 24'h0)  begin fails++; $display("FAIL read0_addr: got %h expected 000000", mosi_a[23:0]); end
    tests++; if (per !== 4)              begin fails++; $display("FAIL read0_clk_period: got %0d expected 4", per); end
    tests++; if (oe_err_a !== 0)         begin fails++; $display("FAIL read0_oeb_phase: got %0d errors expected 0", oe_err_a); end
    tests++; if (csb_a !== 1'b1)         begin fails++; $display("FAIL read0_csb_at_ack: got %b expected 1", csb_a); end
    @(negedge clk);
    tests++; if (ack_a !== 1'b0)  begin fails++; $display("FAIL read0_ack_width: got %b expected 0", ack_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL read0_busy_drop: got %b expected 0", busy_a); end
    tests++; if (rdata_a !== 32'h0B00006F) begin fails++; $display("FAIL read0_rdata_hold: got %h expected 0b00006f", rdata_a); end
  endtask

  task automatic test_read_addr7();
    int lat, per;
    repeat (6) @(negedge clk);
    read_a(24'h000007, 1'b1, lat, per);
    tests++; if (lat !== 261)              begin fails++; $display("FAIL read7_latency: got %0d expected 261", lat); end
    tests++; if (mosi_a[23:0] !== 24'h000004) begin fails++; $display("FAIL read7_addr: got %h expected 000004", mosi_a[23:0]); end
    tests++; if (rdata_a !== 32'hFFA00513) begin fails++; $display("FAIL read7_rdata: got %h expected ffa00513", rdata_a); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, hi;
    logic [31:0] first;
    repeat (6) @(negedge clk);
    addr_a = 24'h000000;
    req_a  = 1'b1;
    n = 0;
    while (!busy_a && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!csb_a && n < 2000) begin @(negedge clk); n++; end
    hi = 0; first = 32'h0;
    while (csb_a && hi < 100) begin
      if (ack_a) first = rdata_a;
      @(negedge clk);
      hi++;
    end
    tests++; if (hi !== 4) begin fails++; $display("FAIL b2b_csb_gap: got %0d expected 4", hi); end
    tests++; if (first !== 32'h0B00006F) begin fails++; $display("FAIL b2b_first_rdata: got %h expected 0b00006f", first); end
    n = 0;
    while (!ack_a && n < 2000) begin @(negedge clk); n++; end
    req_a = 1'b0;
    tests++; if (n !== 261) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 261", n); end
    tests++; if (rdata_a !== 32'h0B00006F) begin fails++; $display("FAIL b2b_second_rdata: got %h expected 0b00006f", rdata_a); end
    repeat (8) @(negedge clk);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL b2b_idle_after: got %b expected 0", busy_a); end
  endtask

  task automatic test_reset_mid();
    int n, lat, per;
    logic saw_ack;
    addr_a = 24'h000004;
    req_a  = 1'b1;
    n = 0;
    while (!busy_a && n < 50) begin @(negedge clk); n++; end
    req_a = 1'b0;
    n = 0;
    while (bits_a != 40 && n < 2000) begin @(negedge clk); n++; end
    tests++; if (bits_a !== 40) begin fails++; $display("FAIL mid_reach_bit40: got %0d expected 40", bits_a); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tests++; if (csb_a !== 1'b1)  begin fails++; $display("FAIL mid_csb: got %b expected 1", csb_a); end
    tests++; if (fclk_a !== 1'b0) begin fails++; $display("FAIL mid_clk: got %b expected 0", fclk_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", busy_a); end
    tests++; if (rdata_a !== 32'h0) begin fails++; $display("FAIL mid_rdata: got %h expected 00000000", rdata_a); end
    saw_ack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ack_a || busy_a) saw_ack = 1'b1;
      @(negedge clk);
    end
    tests++; if (saw_ack !== 1'b0) begin fails++; $display("FAIL mid_no_ack: got %b expected 0", saw_ack); end
    read_a(24'h000000, 1'b0, lat, per);
    tests++; if (lat !== 261) begin fails++; $display("FAIL mid_reread_latency: got %0d expected 261", lat); end
    tests++; if (rdata_a !== 32'h0B00006F) begin fails++; $display("FAIL mid_reread_rdata: got %h expected 0b00006f", rdata_a); end
    @(negedge clk);
  endtask

  task automatic test_clk_div1();
    int lat, per;
    read_b(24'h000000, lat, per);
    tests++; if (lat !== 131) begin fails++; $display("FAIL div1_latency: got %0d expected 131", lat); end
    tests++; if (per !== 2)   begin fails++; $display("FAIL div1_clk_period: got %0d expected 2", per); end
    tests++; if (rdata_b !== 32'h0B00006F) begin fails++; $display("FAIL div1_rdata: got %h expected 0b00006f", rdata_b); end
    tests++; if (mosi_b !== 32'h03000000)  begin fails++; $display("FAIL div1_mosi: got %h expected 03000000", mosi_b); end
    @(negedge clk);
  endtask

  initial begin
    mem[0] = 8'h6F; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h0B;
    mem[4] = 8'h13; mem[5] = 8'h05; mem[6] = 8'hA0; mem[7] = 8'hFF;
    miso_a = 1'b0;
    miso_b = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    addr_a = '0;
    addr_b = '0;
    rstn   = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_addr0();
    test_read_addr7();
    test_back_to_back();
    test_reset_mid();
    test_clk_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
